pc_redirect_ctrl: RTL and testbench
===================================

// Module: pc_redirect_ctrl
// PURPOSE
// Front-end sequencer for the next-PC selector and the IF/ID/EX boundary of the MIPS pipeline.
// - Decodes the ID-stage control flow (beq/bne/j/jr) into the 2-bit pcsrc that drives the next-PC mux.
// - Detects load-use hazards and holds the front end on an instruction-memory wait.
// - Issues PC/IF-ID write enables, the IF/ID flush and the ID/EX bubble.
// - Keeps a fetch-timeout flag and two saturating performance counters.
// PARAMETERS
// BRANCH_FLUSH   1   1: flush IF/ID on a taken redirect (no delay slot); 0: MIPS delay slot kept
// IMISS_TIMEOUT  64  consecutive imem wait cycles before fetch_err sets (>=1)
// CNT_W          32  width of the performance counters
// PORTS
// clk            in   1      rising-edge clock
// rst            in   1      asynchronous, active-high reset
// id_valid       in   1      ID stage holds a real instruction
// id_beq         in   1      ID instr is beq
// id_bne         in   1      ID instr is bne
// id_j           in   1      ID instr is j or jal
// id_jr          in   1      ID instr is jr
// id_uses_rt     in   1      ID instr reads rt as a source
// id_rs          in   5      ID source register rs
// id_rt          in   5      ID source register rt
// id_rs_eq_rt    in   1      ID comparator result (qa == qb)
// ex_mem_read    in   1      EX instr is a load
// ex_rd          in   5      EX destination register
// imem_ready     in   1      instruction memory returns data this cycle
// pcsrc          out  2      0 pc+4, 1 branch target, 2 rs (jr), 3 jump target
// pc_we          out  1      PC register write enable
// ifid_we        out  1      IF/ID register write enable
// ifid_flush     out  1      load a nop into IF/ID
// idex_bubble    out  1      load a nop into ID/EX
// fetch_err      out  1      sticky: imem wait exceeded IMISS_TIMEOUT
// stall_cnt      out  CNT_W  cycles with pc_we=0 while in RUN/IMISS (saturating)
// redirect_cnt   out  CNT_W  taken redirects applied (saturating)
// BEHAVIOUR
// - FSM {BOOT, RUN, IMISS}. Reset: state BOOT, miss counter 0, fetch_err 0, both counters 0.
// - BOOT: pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, pcsrc=0. Next state is always RUN (one cycle).
// - Hazard terms:
//   - lu = id_valid & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
//   - take = id_valid & (j | jr | (beq & eq) | (bne & ~eq)).
// - Priority in RUN/IMISS, evaluated combinationally each cycle:
//   - 1) ~imem_ready: pc_we=0, ifid_we=0, idex_bubble=1, ifid_flush=0, pcsrc=0.
//   - 2) lu: pc_we=0, ifid_we=0, idex_bubble=1, pcsrc=0. The redirect is suppressed because qa/qb are stale.
//   - 3) take: pcsrc per type (j=3, jr=2, branch=1), pc_we=1, ifid_we=1, ifid_flush=BRANCH_FLUSH. redirect_cnt += 1.
//   - 4) otherwise: pcsrc=0, pc_we=1, ifid_we=1, flush/bubble 0.
// - Exactly one of j/jr/beq/bne is asserted by decode. If several are asserted, the order is jr > j > beq/bne.
// - Transitions:
//   - RUN -> IMISS when imem_ready=0.
//   - IMISS -> RUN in the cycle imem_ready=1; that cycle's outputs follow priorities 2-4.
// - Miss counter: increments each IMISS cycle with imem_ready=0. When it reaches IMISS_TIMEOUT it saturates and fetch_err sets.
// - fetch_err clears only on rst. The miss counter clears on entry to RUN.
// - stall_cnt increments on every RUN/IMISS cycle with pc_we=0. BOOT cycles are not counted. Both counters hold at all-ones.
// - Latency: all outputs are combinational from inputs and state, with zero added cycles. State and counters update on the clock edge.
// - rst mid-operation: immediate return to BOOT with all outputs at their BOOT values. Counters and fetch_err clear.
// STRUCTURE
// - Shared package mips_pkg holds the PCSRC_SEQ/BR/JR/J encodings (0..3) and the front-end state enum.
// - Sub-module sat_counter #(W), instanced for stall_cnt, redirect_cnt and the miss counter.
// - Remaining logic (hazard terms, FSM, output decode) is flat in this module.
// TESTING
// - Reset then release, imem_ready=1, no control flow: cycle 0 BOOT (pc_we=0, ifid_flush=1), then pc_we=1, pcsrc=0 every cycle.
// - beq, rs_eq_rt=1, BRANCH_FLUSH=1: pcsrc=1, ifid_flush=1, redirect_cnt 0->1. Same with rs_eq_rt=0: pcsrc=0, no flush.
// - ex_mem_read=1, ex_rd=8, ID jr with rs=8: one cycle pc_we=0, idex_bubble=1, pcsrc=0. Next cycle (EX=bubble): pcsrc=2.
// - Load-use plus imem_ready=0 together: imem hold wins, state IMISS, stall_cnt +1.
// - imem_ready low for 64 cycles (IMISS_TIMEOUT=64): fetch_err=1 after the 64th cycle and stays set after ready returns.
// - rst pulse during IMISS with a pending branch: outputs at BOOT values at once, counters=0, fetch_err=0.
// - Force stall_cnt to near all-ones at CNT_W=4: it saturates at 15 and holds.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared front-end definitions: next-PC mux encodings, sequencer states and the
// per-cycle front-end control bundle.
package mips_pkg;

   localparam int unsigned REG_W   = 5;
   localparam int unsigned PCSRC_W = 2;

   typedef enum logic [PCSRC_W-1:0] {
      PCSRC_SEQ = 2'd0,
      PCSRC_BR  = 2'd1,
      PCSRC_JR  = 2'd2,
      PCSRC_J   = 2'd3
   } pcsrc_e;

   typedef enum logic [1:0] {
      FE_BOOT  = 2'd0,
      FE_RUN   = 2'd1,
      FE_IMISS = 2'd2
   } fe_state_e;

   typedef struct packed {
      pcsrc_e pcsrc;
      logic   pc_we;
      logic   ifid_we;
      logic   ifid_flush;
      logic   idex_bubble;
   } fe_ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at MAX instead of wrapping.
module sat_counter #(
   parameter int unsigned   W   = 8,
   parameter logic [W-1:0]  MAX = '1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != MAX)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Front-end sequencer: next-PC select, load-use / imem-wait holds, IF/ID flush,
// ID/EX bubble, fetch timeout flag and saturating stall/redirect counters.
module pc_redirect_ctrl
   import mips_pkg::*;
#(
   parameter bit          BRANCH_FLUSH  = 1'b1,
   parameter int unsigned IMISS_TIMEOUT = 64,
   parameter int unsigned CNT_W         = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               id_valid,
   input  logic               id_beq,
   input  logic               id_bne,
   input  logic               id_j,
   input  logic               id_jr,
   input  logic               id_uses_rt,
   input  logic [REG_W-1:0]   id_rs,
   input  logic [REG_W-1:0]   id_rt,
   input  logic               id_rs_eq_rt,
   input  logic               ex_mem_read,
   input  logic [REG_W-1:0]   ex_rd,
   input  logic               imem_ready,
   output logic [PCSRC_W-1:0] pcsrc,
   output logic               pc_we,
   output logic               ifid_we,
   output logic               ifid_flush,
   output logic               idex_bubble,
   output logic               fetch_err,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   redirect_cnt
);

   localparam int unsigned       MISS_W   = $clog2(IMISS_TIMEOUT + 1);
   localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(IMISS_TIMEOUT);
   localparam logic [MISS_W-1:0] MISS_PRE = MISS_W'(IMISS_TIMEOUT - 1);

   fe_state_e         state_q, state_d;
   fe_ctrl_t          ctrl;
   pcsrc_e            take_sel;
   logic              lu, take, redirect_apply;
   logic              stall_inc, miss_inc, miss_clr;
   logic              fetch_err_q, fetch_err_d;
   logic [MISS_W-1:0] miss_cnt;

   // Hazard terms from the ID/EX boundary.
   assign lu = id_valid && ex_mem_read && (ex_rd != '0) &&
               ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

   assign take = id_valid &&
                 (id_j || id_jr || (id_beq && id_rs_eq_rt) || (id_bne && !id_rs_eq_rt));

   always_comb begin
      take_sel = PCSRC_BR;
      if (id_jr) begin
         take_sel = PCSRC_JR;
      end else if (id_j) begin
         take_sel = PCSRC_J;
      end
   end

   // Next-state and output decode; imem hold beats load-use beats redirect.
   always_comb begin
      state_d          = state_q;
      ctrl.pcsrc       = PCSRC_SEQ;
      ctrl.pc_we       = 1'b0;
      ctrl.ifid_we     = 1'b0;
      ctrl.ifid_flush  = 1'b0;
      ctrl.idex_bubble = 1'b0;
      redirect_apply   = 1'b0;
      case (state_q)
         FE_BOOT: begin
            ctrl.ifid_flush  = 1'b1;
            ctrl.idex_bubble = 1'b1;
            state_d          = FE_RUN;
         end
         default: begin
            if (!imem_ready) begin
               ctrl.idex_bubble = 1'b1;
               state_d          = FE_IMISS;
            end else begin
               state_d = FE_RUN;
               if (lu) begin
                  ctrl.idex_bubble = 1'b1;
               end else if (take) begin
                  ctrl.pcsrc      = take_sel;
                  ctrl.pc_we      = 1'b1;
                  ctrl.ifid_we    = 1'b1;
                  ctrl.ifid_flush = BRANCH_FLUSH;
                  redirect_apply  = 1'b1;
               end else begin
                  ctrl.pc_we   = 1'b1;
                  ctrl.ifid_we = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FE_BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   assign stall_inc = (state_q != FE_BOOT) && !ctrl.pc_we;
   assign miss_inc  = (state_q == FE_IMISS) && !imem_ready;
   assign miss_clr  = (state_d == FE_RUN);

   // Sets on the same edge the miss counter reaches the timeout; sticky until reset.
   assign fetch_err_d = fetch_err_q || (miss_inc && (miss_cnt == MISS_PRE));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_err_q <= 1'b0;
      end else begin
         fetch_err_q <= fetch_err_d;
      end
   end

   sat_counter #(.W(MISS_W), .MAX(MISS_MAX)) u_miss_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (miss_clr),
      .inc_i (miss_inc),
      .cnt_o (miss_cnt)
   );

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (1'b0),
      .inc_i (stall_inc),
      .cnt_o (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_redirect_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (1'b0),
      .inc_i (redirect_apply),
      .cnt_o (redirect_cnt)
   );

   assign pcsrc       = ctrl.pcsrc;
   assign pc_we       = ctrl.pc_we;
   assign ifid_we     = ctrl.ifid_we;
   assign ifid_flush  = ctrl.ifid_flush;
   assign idex_bubble = ctrl.idex_bubble;
   assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed scenarios with constant expectations, then
// random traffic against a cycle-level reference model of the front-end rules.
module tb_pc_redirect_ctrl;

   localparam int CNT_W   = 4;
   localparam int CNT_MAX = 15;
   localparam int TIMEOUT = 64;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       id_valid, id_beq, id_bne, id_j, id_jr, id_uses_rt, id_rs_eq_rt;
   logic [4:0] id_rs, id_rt, ex_rd;
   logic       ex_mem_read, imem_ready;
   logic [1:0] pcsrc;
   logic       pc_we, ifid_we, ifid_flush, idex_bubble, fetch_err;
   logic [CNT_W-1:0] stall_cnt, redirect_cnt;

   int checks   = 0;
   int failures = 0;

   // Reference model state.
   bit m_boot, m_miss, m_ferr, e_take;
   int m_miss_n, m_stall, m_redir;
   int e_pcsrc;
   bit e_pc_we, e_ifid_we, e_flush, e_bubble;

   pc_redirect_ctrl #(.BRANCH_FLUSH(1'b1), .IMISS_TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_beq(id_beq), .id_bne(id_bne),
      .id_j(id_j), .id_jr(id_jr), .id_uses_rt(id_uses_rt), .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_eq_rt(id_rs_eq_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
      .imem_ready(imem_ready), .pcsrc(pcsrc), .pc_we(pc_we), .ifid_we(ifid_we),
      .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .fetch_err(fetch_err),
      .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void model_reset();
      m_boot = 1; m_miss = 0; m_ferr = 0; m_miss_n = 0; m_stall = 0; m_redir = 0;
   endfunction

   // Expected combinational outputs for the current inputs and model state.
   function automatic void model_eval();
      bit lu, tk;
      lu = id_valid && ex_mem_read && ex_rd != 0 &&
           (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
      tk = id_valid && (id_j || id_jr || (id_beq && id_rs_eq_rt) || (id_bne && !id_rs_eq_rt));
      e_pcsrc = 0; e_pc_we = 0; e_ifid_we = 0; e_flush = 0; e_bubble = 0; e_take = 0;
      if (m_boot) begin
         e_flush = 1; e_bubble = 1;
      end else if (!imem_ready || lu) begin
         e_bubble = 1;
      end else if (tk) begin
         e_pcsrc = id_jr ? 2 : (id_j ? 3 : 1);
         e_pc_we = 1; e_ifid_we = 1; e_flush = 1; e_take = 1;
      end else begin
         e_pc_we = 1; e_ifid_we = 1;
      end
   endfunction

   function automatic void model_step();
      if (m_boot) begin
         m_boot = 0; m_miss = 0; m_miss_n = 0;
      end else begin
         if (!e_pc_we && m_stall < CNT_MAX) m_stall++;
         if (e_take && m_redir < CNT_MAX) m_redir++;
         if (!imem_ready) begin
            if (m_miss && m_miss_n < TIMEOUT) m_miss_n++;
            if (m_miss_n == TIMEOUT) m_ferr = 1;
            m_miss = 1;
         end else begin
            m_miss = 0; m_miss_n = 0;
         end
      end
   endfunction

   task automatic idle();
      id_valid = 0; id_beq = 0; id_bne = 0; id_j = 0; id_jr = 0; id_uses_rt = 0;
      id_rs = 0; id_rt = 0; id_rs_eq_rt = 0; ex_mem_read = 0; ex_rd = 0; imem_ready = 1;
   endtask

   task automatic settle();
      @(negedge clk);
      model_eval();
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   // Leaves the bench at posedge+1 with the DUT in its BOOT cycle.
   task automatic do_reset();
      idle();
      rst = 1;
      model_reset();
      @(posedge clk);
      #1 rst = 0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1;
      #1;
      checks++;
      if ({pcsrc, pc_we, ifid_we, ifid_flush, idex_bubble} !== 6'b000011) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=000011", {pcsrc, pc_we, ifid_we, ifid_flush, idex_bubble});
      end
      checks++;
      if ({fetch_err, stall_cnt, redirect_cnt} !== 9'd0) begin
         failures++;
         $display("FAIL reset_counters got ferr=%b stall=%0d redir=%0d exp all 0", fetch_err, stall_cnt, redirect_cnt);
      end
      model_reset();
      @(posedge clk);
      #1 rst = 0;
      settle();
      checks++;
      if (pc_we !== 1'b0 || ifid_flush !== 1'b1) begin
         failures++;
         $display("FAIL boot_cycle got pc_we=%b flush=%b exp pc_we=0 flush=1", pc_we, ifid_flush);
      end
      tick();
      for (int i = 0; i < 5; i++) begin
         settle();
         checks++;
         if ({pcsrc, pc_we, ifid_we, ifid_flush, idex_bubble} !== 6'b001100) begin
            failures++;
            $display("FAIL run_seq[%0d] got=%b exp=001100", i, {pcsrc, pc_we, ifid_we, ifid_flush, idex_bubble});
         end
         tick();
      end
      checks++;
      if (stall_cnt !== 4'd0) begin
         failures++;
         $display("FAIL boot_not_stall got=%0d exp=0", stall_cnt);
      end
   endtask

   task automatic test_branch();
      do_reset(); settle(); tick();
      id_valid = 1; id_beq = 1; id_rs_eq_rt = 1;
      settle();
      checks++;
      if (pcsrc !== 2'd1 || ifid_flush !== 1'b1 || redirect_cnt !== 4'd0) begin
         failures++;
         $display("FAIL beq_taken got pcsrc=%0d flush=%b redir=%0d exp 1 1 0", pcsrc, ifid_flush, redirect_cnt);
      end
      tick();
      checks++;
      if (redirect_cnt !== 4'd1) begin
         failures++;
         $display("FAIL beq_redir_cnt got=%0d exp=1", redirect_cnt);
      end
      id_rs_eq_rt = 0;
      settle();
      checks++;
      if (pcsrc !== 2'd0 || ifid_flush !== 1'b0 || pc_we !== 1'b1) begin
         failures++;
         $display("FAIL beq_not_taken got pcsrc=%0d flush=%b pc_we=%b exp 0 0 1", pcsrc, ifid_flush, pc_we);
      end
      tick();
      id_beq = 0; id_bne = 1;
      settle();
      checks++;
      if (pcsrc !== 2'd1) begin
         failures++;
         $display("FAIL bne_taken got pcsrc=%0d exp=1", pcsrc);
      end
      tick();
      id_bne = 0; id_j = 1; id_jr = 1;
      settle();
      checks++;
      if (pcsrc !== 2'd2) begin
         failures++;
         $display("FAIL jr_over_j got pcsrc=%0d exp=2", pcsrc);
      end
      tick();
      id_jr = 0;
      settle();
      checks++;
      if (pcsrc !== 2'd3) begin
         failures++;
         $display("FAIL j_taken got pcsrc=%0d exp=3", pcsrc);
      end
      tick();
      checks++;
      if (redirect_cnt !== 4'd4) begin
         failures++;
         $display("FAIL redir_total got=%0d exp=4", redirect_cnt);
      end
   endtask

   task automatic test_load_use_jr();
      do_reset(); settle(); tick();
      id_valid = 1; id_jr = 1; id_rs = 5'd8; ex_mem_read = 1; ex_rd = 5'd8;
      settle();
      checks++;
      if (pc_we !== 1'b0 || idex_bubble !== 1'b1 || pcsrc !== 2'd0) begin
         failures++;
         $display("FAIL lu_hold got pc_we=%b bubble=%b pcsrc=%0d exp 0 1 0", pc_we, idex_bubble, pcsrc);
      end
      tick();
      ex_mem_read = 0; ex_rd = 0;
      settle();
      checks++;
      if (pcsrc !== 2'd2 || pc_we !== 1'b1) begin
         failures++;
         $display("FAIL lu_release got pcsrc=%0d pc_we=%b exp 2 1", pcsrc, pc_we);
      end
      tick();
      checks++;
      if (stall_cnt !== 4'd1 || redirect_cnt !== 4'd1) begin
         failures++;
         $display("FAIL lu_counts got stall=%0d redir=%0d exp 1 1", stall_cnt, redirect_cnt);
      end
   endtask

   task automatic test_lu_imiss();
      do_reset(); settle(); tick();
      id_valid = 1; id_beq = 1; id_rs_eq_rt = 1; id_uses_rt = 1; id_rt = 5'd3;
      ex_mem_read = 1; ex_rd = 5'd3; imem_ready = 0;
      settle();
      checks++;
      if ({pcsrc, pc_we, ifid_we, ifid_flush, idex_bubble} !== 6'b000001) begin
         failures++;
         $display("FAIL lu_imiss got=%b exp=000001", {pcsrc, pc_we, ifid_we, ifid_flush, idex_bubble});
      end
      tick();
      checks++;
      if (stall_cnt !== 4'd1) begin
         failures++;
         $display("FAIL lu_imiss_stall got=%0d exp=1", stall_cnt);
      end
      imem_ready = 1;
      settle();
      checks++;
      if (pc_we !== 1'b0 || idex_bubble !== 1'b1) begin
         failures++;
         $display("FAIL imiss_exit_lu got pc_we=%b bubble=%b exp 0 1", pc_we, idex_bubble);
      end
      tick();
      ex_mem_read = 0;
      settle();
      checks++;
      if (pcsrc !== 2'd1 || stall_cnt !== 4'd2) begin
         failures++;
         $display("FAIL imiss_then_branch got pcsrc=%0d stall=%0d exp 1 2", pcsrc, stall_cnt);
      end
      tick();
   endtask

   // One RUN cycle enters IMISS, then TIMEOUT counted IMISS cycles set fetch_err.
   task automatic test_timeout_and_mid_reset();
      do_reset(); settle(); tick();
      imem_ready = 0;
      for (int i = 0; i < TIMEOUT; i++) begin
         settle(); tick();
      end
      checks++;
      if (fetch_err !== 1'b0) begin
         failures++;
         $display("FAIL timeout_early got=%b exp=0", fetch_err);
      end
      settle(); tick();
      checks++;
      if (fetch_err !== 1'b1 || stall_cnt !== 4'd15) begin
         failures++;
         $display("FAIL timeout_set got ferr=%b stall=%0d exp 1 15", fetch_err, stall_cnt);
      end
      imem_ready = 1;
      repeat (3) begin settle(); tick(); end
      checks++;
      if (fetch_err !== 1'b1) begin
         failures++;
         $display("FAIL timeout_sticky got=%b exp=1", fetch_err);
      end
      imem_ready = 0; id_valid = 1; id_beq = 1; id_rs_eq_rt = 1;
      settle(); tick();
      settle();
      rst = 1;
      #1;
      checks++;
      if ({pcsrc, pc_we, ifid_we, ifid_flush, idex_bubble} !== 6'b000011 ||
          {fetch_err, stall_cnt, redirect_cnt} !== 9'd0) begin
         failures++;
         $display("FAIL mid_reset got ctrl=%b ferr=%b stall=%0d redir=%0d exp 000011 0 0 0",
                  {pcsrc, pc_we, ifid_we, ifid_flush, idex_bubble}, fetch_err, stall_cnt, redirect_cnt);
      end
      model_reset();
      @(posedge clk);
      #1 rst = 0;
      idle();
      settle(); tick();
      settle();
      checks++;
      if (pc_we !== 1'b1 || fetch_err !== 1'b0) begin
         failures++;
         $display("FAIL after_mid_reset got pc_we=%b ferr=%b exp 1 0", pc_we, fetch_err);
      end
      tick();
   endtask

   task automatic test_stall_saturation();
      do_reset(); settle(); tick();
      imem_ready = 0;
      repeat (14) begin settle(); tick(); end
      checks++;
      if (stall_cnt !== 4'd14) begin
         failures++;
         $display("FAIL stall_14 got=%0d exp=14", stall_cnt);
      end
      settle(); tick();
      checks++;
      if (stall_cnt !== 4'd15) begin
         failures++;
         $display("FAIL stall_15 got=%0d exp=15", stall_cnt);
      end
      repeat (3) begin settle(); tick(); end
      checks++;
      if (stall_cnt !== 4'd15) begin
         failures++;
         $display("FAIL stall_hold got=%0d exp=15", stall_cnt);
      end
   endtask

   task automatic test_random();
      int burst = 0;
      logic [14:0] obs, exp_v;
      for (int r = 0; r < 3; r++) begin
         do_reset();
         for (int i = 0; i < 1000; i++) begin
            id_valid    = ($urandom_range(0, 7) != 0);
            id_beq      = ($urandom_range(0, 3) == 0);
            id_bne      = ($urandom_range(0, 3) == 0);
            id_j        = ($urandom_range(0, 5) == 0);
            id_jr       = ($urandom_range(0, 5) == 0);
            id_uses_rt  = 1'($urandom_range(0, 1));
            id_rs_eq_rt = 1'($urandom_range(0, 1));
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            ex_rd       = 5'($urandom_range(0, 3));
            ex_mem_read = ($urandom_range(0, 2) == 0);
            if (burst == 0 && $urandom_range(0, 199) == 0) burst = 70;
            if (burst > 0) begin
               imem_ready = 0;
               burst--;
            end else begin
               imem_ready = ($urandom_range(0, 5) != 0);
            end
            settle();
            obs   = {pcsrc, pc_we, ifid_we, ifid_flush, idex_bubble, fetch_err, stall_cnt, redirect_cnt};
            exp_v = {2'(e_pcsrc), e_pc_we, e_ifid_we, e_flush, e_bubble, m_ferr, 4'(m_stall), 4'(m_redir)};
            checks++;
            if (obs !== exp_v) begin
               failures++;
               $display("FAIL random[%0d.%0d] got=%b exp=%b", r, i, obs, exp_v);
            end
            tick();
         end
      end
   endtask

   initial begin
      idle();
      test_reset();
      test_branch();
      test_load_use_jr();
      test_lu_imiss();
      test_timeout_and_mid_reset();
      test_stall_saturation();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
